sync_fifo: RTL and testbench

- Single-clock, first-in first-out buffer for 16-bit samples between a producer and a consumer in the FIR filter datapath.
- Accepts a word on each enabled write while not full. Returns words in order on each enabled read while not empty.
- Provides full and empty status flags for flow control.

---
 rtl/sync_fifo_if.sv | 30 +++
 rtl/sync_fifo.sv | 79 +++++++
 tb/tb_sync_fifo.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Handshake bundle between a producer/consumer pair and the sync_fifo.
// The master side drives requests and write data; the slave (the FIFO) returns flags and read data.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  full;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_en;
  logic                  empty;

  modport master (
    output wr_data,
    output wr_en,
    output rd_en,
    input  full,
    input  empty,
    input  rd_data
  );

  modport slave (
    input  wr_data,
    input  wr_en,
    input  rd_en,
    output full,
    output empty,
    output rd_data
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO for 16-bit FIR samples: registered read data, occupancy-count based flags.
// Synchronous active-low reset clears control state and rd_data; the storage array is left as is.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic          clk,
  input  logic          rst,
  sync_fifo_if.slave    bus
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic full, empty;
  logic wr_acc, rd_acc;

  // Flags come straight from the registered count, so they only move after an edge.
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  assign wr_acc = rst & bus.wr_en & ~full;
  assign rd_acc = rst & bus.rd_en & ~empty;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;

    if (wr_acc) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_acc) begin
      rptr_d    = rptr_q + 1'b1;
      rd_data_d = mem_q[rptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Read and write never target the same entry in one cycle: a read needs a stored word,
  // and when full the write is refused.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wptr_q] <= bus.wr_data;
    end
  end

  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: reset, ordering, overflow/underflow, simultaneous access, wrap, mid-run reset.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst;

  int n_cmp = 0;
  int n_err = 0;

  sync_fifo_if #(.DATA_WIDTH(16)) bus ();

  sync_fifo #(
    .DATA_WIDTH(16),
    .DEPTH     (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] q [$];

  initial begin
    rst          = 1'b0;
    bus.wr_en    = 1'b1;
    bus.rd_en    = 1'b1;
    bus.wr_data  = 16'hABCD;

    // Reset held two cycles with both requests active
    step();
    step();
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'h0);
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    step();
    chk("rst_no_write", 32'(bus.empty), 32'd1);

    // Write 1..5 then read them back
    bus.wr_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.wr_data = 16'(i);
      step();
      if (i == 1) chk("wr_empty_fall", 32'(bus.empty), 32'd0);
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("rd_order", 32'(bus.rd_data), 32'(i));
    end
    chk("rd_empty_after5", 32'(bus.empty), 32'd1);

    // Underflow: keep reading while empty
    for (int k = 0; k < 3; k++) begin
      step();
      chk("uf_rd_data", 32'(bus.rd_data), 32'h5);
      chk("uf_empty", 32'(bus.empty), 32'd1);
    end
    bus.rd_en = 1'b0;

    // Fill to full, overflow write, drain
    bus.wr_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.wr_data = 16'(i);
      step();
      if (i < 16) chk("fill_not_full", 32'(bus.full), 32'd0);
    end
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_not_empty", 32'(bus.empty), 32'd0);
    bus.wr_data = 16'hFFFF;
    step();
    chk("ovf_full", 32'(bus.full), 32'd1);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("drain_order", 32'(bus.rd_data), 32'(i));
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    bus.rd_en = 1'b0;

    // Simultaneous read/write at count 3
    bus.wr_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.wr_data = 16'(32'hA0 + i);
      step();
    end
    bus.rd_en   = 1'b1;
    bus.wr_data = 16'h00A4;
    step();
    chk("sim3_rd_data", 32'(bus.rd_data), 32'hA1);
    bus.wr_en = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      chk("sim3_not_empty", 32'(bus.empty), 32'd0);
      step();
      chk("sim3_order", 32'(bus.rd_data), 32'(32'hA0 + i));
    end
    chk("sim3_empty", 32'(bus.empty), 32'd1);
    bus.rd_en = 1'b0;

    // Simultaneous read/write at full: write dropped
    bus.wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.wr_data = 16'(32'h100 + i);
      step();
    end
    chk("simf_full", 32'(bus.full), 32'd1);
    bus.rd_en   = 1'b1;
    bus.wr_data = 16'hDEAD;
    step();
    chk("simf_rd_data", 32'(bus.rd_data), 32'h100);
    chk("simf_not_full", 32'(bus.full), 32'd0);
    bus.wr_en = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("simf_order", 32'(bus.rd_data), 32'(32'h100 + i));
    end
    chk("simf_empty", 32'(bus.empty), 32'd1);

    // Simultaneous read/write at empty: read refused, write lands
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'h0777;
    step();
    chk("sime_rd_hold", 32'(bus.rd_data), 32'h10F);
    chk("sime_not_empty", 32'(bus.empty), 32'd0);
    bus.wr_en = 1'b0;
    step();
    chk("sime_rd_new", 32'(bus.rd_data), 32'h777);
    chk("sime_empty", 32'(bus.empty), 32'd1);
    bus.rd_en = 1'b0;

    // 40-word stream with interleaved reads, crossing pointer wrap
    for (int i = 0; i < 40; i++) begin
      logic        wacc, racc;
      logic [15:0] exp_d;
      bus.wr_en   = 1'b1;
      bus.wr_data = 16'(32'h2000 + i);
      bus.rd_en   = ((i % 3) != 0);
      wacc  = (q.size() < 16);
      racc  = bus.rd_en && (q.size() > 0);
      exp_d = 16'h0;
      if (racc) exp_d = q.pop_front();
      if (wacc) q.push_back(bus.wr_data);
      step();
      if (racc) chk("wrap_stream", 32'(bus.rd_data), 32'(exp_d));
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    while (q.size() > 0) begin
      logic [15:0] exp_d;
      exp_d = q.pop_front();
      step();
      chk("wrap_drain", 32'(bus.rd_data), 32'(exp_d));
    end
    chk("wrap_empty", 32'(bus.empty), 32'd1);
    bus.rd_en = 1'b0;

    // Reset with 7 words stored
    bus.wr_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.wr_data = 16'(32'h300 + i);
      step();
    end
    bus.wr_en = 1'b0;
    chk("mid_not_empty", 32'(bus.empty), 32'd0);
    rst = 1'b0;
    step();
    chk("mid_rst_empty", 32'(bus.empty), 32'd1);
    chk("mid_rst_rd_data", 32'(bus.rd_data), 32'h0);
    chk("mid_rst_full", 32'(bus.full), 32'd0);
    rst         = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'h0BEE;
    step();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    chk("mid_new_word", 32'(bus.rd_data), 32'hBEE);
    chk("mid_final_empty", 32'(bus.empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
